// File: rtl/vm1_regfile_pkg.sv
// Shared types and defaults for the vm1 dual-port register file.
package vm1_regfile_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        CLEAR = 1'b1
    } state_t;

    localparam int DEF_DATA_W = 16;
    localparam int DEF_ADDR_W = 6;

    function automatic int lane_count(input int data_w);
        return data_w / 8;
    endfunction

endpackage

// File: rtl/vm1_regfile_lane.sv
// One 8-bit lane: two synchronous write ports (A has priority) and two
// combinational reads of the stored contents; forwarding is done by the top.
module vm1_regfile_lane #(
    parameter int ADDR_W = 6
) (
    input  logic              clock,
    input  logic              we_a_i,
    input  logic [ADDR_W-1:0] wr_addr_a_i,
    input  logic [7:0]        data_a_i,
    input  logic [ADDR_W-1:0] rd_addr_a_i,
    input  logic              we_b_i,
    input  logic [ADDR_W-1:0] addr_b_i,
    input  logic [7:0]        data_b_i,
    output logic [7:0]        rd_a_o,
    output logic [7:0]        rd_b_o
);

    logic [7:0] mem_q [2**ADDR_W];

    // Contents are never reset; the A write is ordered last so it wins a collision.
    always_ff @(posedge clock) begin
        if (we_b_i) begin
            mem_q[addr_b_i] <= data_b_i;
        end
        if (we_a_i) begin
            mem_q[wr_addr_a_i] <= data_a_i;
        end
    end

    assign rd_a_o = mem_q[rd_addr_a_i];
    assign rd_b_o = mem_q[addr_b_i];

endmodule

// File: rtl/vm1_regfile_dpram.sv
// Byte-enabled true-dual-port register file with a clear sweep after reset
// or on init_req. Port A wins same-lane collisions; both ports read the merge.
module vm1_regfile_dpram
    import vm1_regfile_pkg::*;
#(
    parameter int                DATA_W     = DEF_DATA_W,
    parameter int                ADDR_W     = DEF_ADDR_W,
    parameter logic [DATA_W-1:0] INIT_VALUE = '0
) (
    input  logic                          clock,
    input  logic                          reset,
    input  logic [ADDR_W-1:0]             address_a,
    input  logic [DATA_W-1:0]             data_a,
    input  logic [lane_count(DATA_W)-1:0] byteena_a,
    input  logic                          wren_a,
    output logic [DATA_W-1:0]             q_a,
    input  logic [ADDR_W-1:0]             address_b,
    input  logic [DATA_W-1:0]             data_b,
    input  logic [lane_count(DATA_W)-1:0] byteena_b,
    input  logic                          wren_b,
    output logic [DATA_W-1:0]             q_b,
    input  logic                          init_req,
    output logic                          busy
);

    localparam int                LANES    = lane_count(DATA_W);
    localparam logic [ADDR_W-1:0] CNT_LAST = '1;
    localparam logic [ADDR_W-1:0] CNT_ONE  = {{(ADDR_W-1){1'b0}}, 1'b1};

    state_t             state_q, state_d;
    logic [ADDR_W-1:0]  cnt_q, cnt_d;
    logic [DATA_W-1:0]  q_a_q, q_b_q;
    logic [DATA_W-1:0]  rd_a, rd_b;
    logic               clearing, port_en, same_addr, blank_q;

    assign clearing  = (state_q == CLEAR);
    assign port_en   = ~clearing;
    assign same_addr = (address_a == address_b);
    // Outputs read 0 for every cycle busy is high, including the entry and exit edges.
    assign blank_q   = clearing | (state_d == CLEAR);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: begin
                if (init_req) begin
                    state_d = CLEAR;
                end
            end
            CLEAR: begin
                cnt_d = cnt_q + CNT_ONE;
                if (cnt_q == CNT_LAST) begin
                    state_d = IDLE;
                end
            end
        endcase
    end

    for (genvar k = 0; k < LANES; k++) begin : g_lane
        logic              wr_a, wr_b, lane_we_a;
        logic [ADDR_W-1:0] lane_addr_a;
        logic [7:0]        lane_din_a, byte_a, byte_b, old_a, old_b;

        assign byte_a      = data_a[8*k +: 8];
        assign byte_b      = data_b[8*k +: 8];
        assign wr_a        = port_en & wren_a & byteena_a[k];
        assign wr_b        = port_en & wren_b & byteena_b[k];
        // The sweep borrows the A write port while the user ports are locked out.
        assign lane_we_a   = clearing | wr_a;
        assign lane_addr_a = clearing ? cnt_q : address_a;
        assign lane_din_a  = clearing ? INIT_VALUE[8*k +: 8] : byte_a;

        vm1_regfile_lane #(
            .ADDR_W(ADDR_W)
        ) u_lane (
            .clock      (clock),
            .we_a_i     (lane_we_a),
            .wr_addr_a_i(lane_addr_a),
            .data_a_i   (lane_din_a),
            .rd_addr_a_i(address_a),
            .we_b_i     (wr_b),
            .addr_b_i   (address_b),
            .data_b_i   (byte_b),
            .rd_a_o     (old_a),
            .rd_b_o     (old_b)
        );

        // Each port returns exactly what the lane will hold after this edge.
        assign rd_a[8*k +: 8] = wr_a ? byte_a : ((wr_b && same_addr) ? byte_b : old_a);
        assign rd_b[8*k +: 8] = (wr_a && same_addr) ? byte_a : (wr_b ? byte_b : old_b);
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= CLEAR;
            cnt_q   <= '0;
            q_a_q   <= '0;
            q_b_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            q_a_q   <= blank_q ? '0 : rd_a;
            q_b_q   <= blank_q ? '0 : rd_b;
        end
    end

    assign busy = clearing;
    assign q_a  = q_a_q;
    assign q_b  = q_b_q;

endmodule

// File: tb/tb_vm1_regfile_dpram.sv
// Bench for vm1_regfile_dpram: word-level memory model, per-cycle scoreboard,
// directed scenarios with literal expectations, and a randomized phase.
module tb_vm1_regfile_dpram;

    localparam int            DW    = 16;
    localparam int            AW    = 6;
    localparam int            NL    = DW / 8;
    localparam int            DEPTH = 64;
    localparam logic [DW-1:0] INIT  = 16'h0000;

    logic          clock = 1'b0;
    logic          reset = 1'b0;
    logic [AW-1:0] address_a = '0;
    logic [DW-1:0] data_a = '0;
    logic [NL-1:0] byteena_a = '0;
    logic          wren_a = 1'b0;
    logic [DW-1:0] q_a;
    logic [AW-1:0] address_b = '0;
    logic [DW-1:0] data_b = '0;
    logic [NL-1:0] byteena_b = '0;
    logic          wren_b = 1'b0;
    logic [DW-1:0] q_b;
    logic          init_req = 1'b0;
    logic          busy;

    always #5 clock = ~clock;

    vm1_regfile_dpram #(
        .DATA_W    (DW),
        .ADDR_W    (AW),
        .INIT_VALUE(INIT)
    ) dut (
        .clock    (clock),
        .reset    (reset),
        .address_a(address_a),
        .data_a   (data_a),
        .byteena_a(byteena_a),
        .wren_a   (wren_a),
        .q_a      (q_a),
        .address_b(address_b),
        .data_b   (data_b),
        .byteena_b(byteena_b),
        .wren_b   (wren_b),
        .q_b      (q_b),
        .init_req (init_req),
        .busy     (busy)
    );

    int tests_run    = 0;
    int tests_failed = 0;

    // Expected post-edge outputs: {busy, q_a, q_b}
    logic [2*DW:0] exp_q[$];

    logic [DW-1:0] mem_m [DEPTH];
    logic          busy_m = 1'b1;
    int            sweep_idx = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests_run++;
        if (act !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Word-level model: while sweeping, one location per edge is cleared and the
    // ports are ignored; otherwise B lanes then A lanes land, and each port
    // returns its address as it stands after the edge.
    task automatic model_edge();
        logic [DW-1:0] qa, qb;
        if (busy_m) begin
            mem_m[sweep_idx] = INIT;
            sweep_idx++;
            if (sweep_idx == DEPTH) begin
                busy_m    = 1'b0;
                sweep_idx = 0;
            end
            qa = '0;
            qb = '0;
        end else begin
            for (int k = 0; k < NL; k++) begin
                if (wren_b && byteena_b[k]) mem_m[address_b][8*k +: 8] = data_b[8*k +: 8];
            end
            for (int k = 0; k < NL; k++) begin
                if (wren_a && byteena_a[k]) mem_m[address_a][8*k +: 8] = data_a[8*k +: 8];
            end
            if (init_req) begin
                busy_m    = 1'b1;
                sweep_idx = 0;
                qa        = '0;
                qb        = '0;
            end else begin
                qa = mem_m[address_a];
                qb = mem_m[address_b];
            end
        end
        exp_q.push_back({busy_m, qa, qb});
    endtask

    always @(negedge clock) begin
        logic [2*DW:0] e;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check("busy", {31'd0, busy}, {31'd0, e[2*DW]});
            check("q_a", {16'd0, q_a}, {16'd0, e[2*DW-1:DW]});
            check("q_b", {16'd0, q_b}, {16'd0, e[DW-1:0]});
        end
    end

    // Called at negedge+1; returns at the next negedge+1 with outputs settled.
    task automatic step(input logic wa, input logic [AW-1:0] aa, input logic [DW-1:0] da,
                        input logic [NL-1:0] ba, input logic wb, input logic [AW-1:0] ab,
                        input logic [DW-1:0] db, input logic [NL-1:0] bb, input logic ir);
        wren_a = wa; address_a = aa; data_a = da; byteena_a = ba;
        wren_b = wb; address_b = ab; data_b = db; byteena_b = bb;
        init_req = ir;
        model_edge();
        @(posedge clock);
        @(negedge clock);
        #1;
    endtask

    task automatic step_idle();
        step(1'b0, AW'($urandom_range(0, DEPTH-1)), DW'($urandom), '1,
             1'b0, AW'($urandom_range(0, DEPTH-1)), DW'($urandom), '1, 1'b0);
    endtask

    task automatic do_reset();
        wren_a = 1'b0; wren_b = 1'b0; init_req = 1'b0;
        reset = 1'b1;
        #1;
        check("rst_busy", {31'd0, busy}, 32'd1);
        check("rst_q_a", {16'd0, q_a}, 32'd0);
        check("rst_q_b", {16'd0, q_b}, 32'd0);
        repeat (2) @(negedge clock);
        #1;
        reset = 1'b0;
        exp_q.delete();
        busy_m    = 1'b1;
        sweep_idx = 0;
    endtask

    // Counts busy edges; near the end of a full sweep it attempts writes that must be dropped.
    task automatic measure_sweep(output int n);
        n = 0;
        while (busy === 1'b1 && n < 200) begin
            if (n == 60) step(1'b1, 6'd0, 16'hFFFF, '1, 1'b1, 6'd1, 16'hFFFF, '1, 1'b0);
            else         step_idle();
            n++;
        end
    endtask

    task automatic check_lost_writes();
        step(1'b0, 6'd0, 16'h0, '0, 1'b0, 6'd1, 16'h0, '0, 1'b0);
        check("lost_write_a", {16'd0, q_a}, {16'd0, INIT});
        check("lost_write_b", {16'd0, q_b}, {16'd0, INIT});
    endtask

    initial begin
        int n;
        #2;
        do_reset();
        measure_sweep(n);
        check("post_reset_sweep_len", n, 32'd64);
        check_lost_writes();

        step(1'b0, 6'h3F, 16'h0, '0, 1'b0, 6'h00, 16'h0, '0, 1'b0);
        check("read_3f", {16'd0, q_a}, 32'h0000);

        step(1'b1, 6'd5, 16'h1234, 2'b11, 1'b0, 6'd0, 16'h0, 2'b00, 1'b0);
        step(1'b1, 6'd5, 16'hAB00, 2'b10, 1'b0, 6'd0, 16'h0, 2'b00, 1'b0);
        step(1'b0, 6'd0, 16'h0, 2'b00, 1'b0, 6'd5, 16'h0, 2'b00, 1'b0);
        check("byte_write", {16'd0, q_b}, 32'hAB34);

        step(1'b1, 6'd9, 16'h1111, 2'b11, 1'b1, 6'd9, 16'h2222, 2'b11, 1'b0);
        check("collision_q_a", {16'd0, q_a}, 32'h1111);
        check("collision_q_b", {16'd0, q_b}, 32'h1111);
        step(1'b0, 6'd9, 16'h0, 2'b00, 1'b0, 6'd9, 16'h0, 2'b00, 1'b0);
        check("collision_stored", {16'd0, q_a}, 32'h1111);

        step(1'b1, 6'd12, 16'h00CC, 2'b01, 1'b1, 6'd12, 16'hDD00, 2'b10, 1'b0);
        check("merge_disjoint", {16'd0, q_b}, 32'hDDCC);

        step(1'b1, 6'd3, 16'hBEEF, 2'b11, 1'b0, 6'd3, 16'h0, 2'b00, 1'b0);
        check("bypass", {16'd0, q_b}, 32'hBEEF);

        step(1'b0, 6'd0, 16'h0, '0, 1'b0, 6'd0, 16'h0, '0, 1'b1);
        measure_sweep(n);
        check("init_sweep_len", n, 32'd64);
        check_lost_writes();

        step(1'b0, 6'd0, 16'h0, '0, 1'b0, 6'd0, 16'h0, '0, 1'b1);
        repeat (10) step_idle();
        step(1'b0, 6'd0, 16'h0, '0, 1'b0, 6'd0, 16'h0, '0, 1'b1);
        measure_sweep(n);
        check("init_while_busy_ignored", n, 32'd53);

        step(1'b0, 6'd0, 16'h0, '0, 1'b0, 6'd0, 16'h0, '0, 1'b1);
        repeat (20) step_idle();
        do_reset();
        measure_sweep(n);
        check("mid_sweep_reset_len", n, 32'd64);
        check_lost_writes();

        for (int i = 0; i < 1500; i++) begin
            logic [AW-1:0] aa, ab;
            aa = ($urandom_range(0, 1) == 0) ? AW'($urandom_range(0, 7)) : AW'($urandom_range(0, DEPTH-1));
            ab = ($urandom_range(0, 1) == 0) ? AW'($urandom_range(0, 7)) : AW'($urandom_range(0, DEPTH-1));
            step(1'($urandom_range(0, 1)), aa, DW'($urandom), NL'($urandom_range(0, 3)),
                 1'($urandom_range(0, 1)), ab, DW'($urandom), NL'($urandom_range(0, 3)),
                 ($urandom_range(0, 149) == 0));
        end
        measure_sweep(n);
        repeat (4) step_idle();

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation still running at %0t", $time);
        $fatal(1, "watchdog expired");
    end

endmodule
